clock_gen: RTL and testbench
============================

# clock_gen

Parametrised CPU clock generator, the successor to `clock`. It derives `cpu_clk` from `sys_clk` in two modes: a free-running mode with a runtime-programmable divider, and a manual single-step mode driven by a debounced push button. Mode changes are glitch-free, and a latching halt responds to the control unit's HLT. The block sits between the board IO (slide switch, button) and every `cpu_clk` consumer in the CPU.

## Interface
- `DIV_WIDTH`, 24: width of the `div` port and of the phase counter.
- `DEBOUNCE_CYCLES`, 270000: consecutive stable `sys_clk` cycles required to accept a new input level (10 ms at 27 MHz).
- `COUNT_WIDTH`, 16: width of `cycle_count`.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  1  raw slide switch, asynchronous; 1 = auto, 0 = manual.
- `manual_toggle`  in  1  raw push button, asynchronous, bouncy; 1 = pressed.
- `halt`  in  1  halt request from control, synchronous to `sys_clk`.
- `div`  in  DIV_WIDTH  auto-mode half-period in `sys_clk` cycles; 0 is treated as 1.
- `cpu_clk`  out  1  registered CPU clock.
- `cpu_rise`  out  1  one-cycle pulse, high in the first `sys_clk` cycle in which `cpu_clk` = 1.
- `halted`  out  1  high while the generator is latched in the halted state.
- `cycle_count`  out  COUNT_WIDTH  count of `cpu_clk` rising edges since reset; wraps.

## Operation
- Both `mode` and `manual_toggle` pass through a `debouncer`. Each `debouncer` is a 2-FF synchroniser followed by a stability counter.
  - The stable output flips on the clock edge that ends the DEBOUNCE_CYCLES-th consecutive cycle in which the synchronised input differs from the stable value.
  - Any cycle in which the two match clears the counter.
  - The stable output resets to 0.
- `btn_rise` is a one-cycle pulse on a 0→1 transition of the debounced button.
- `mode_q` is the active mode. It loads the debounced `mode` only in state LOW. On that load, the phase counter clears.
- FSM states are LOW, HIGH and HALTED. `cpu_clk` = 1 only in HIGH.
  - Each phase entry clears `cnt` and latches `div_eff` = max(`div`, 1). A `div` change therefore applies from the next phase boundary.
  - LOW → HIGH (auto): `cnt` = `div_eff` − 1 and `halt` = 0.
  - LOW → HIGH (manual): `btn_rise` and `halt` = 0.
  - HIGH → LOW (auto): `cnt` = `div_eff` − 1.
  - HIGH → LOW (manual): debounced button = 0.
  - LOW → HALTED: the cycle that would otherwise trigger LOW → HIGH sees `halt` = 1.
  - HALTED is exited only by `rst`. `halt` is ignored in HIGH; the high phase always completes.
- `btn_rise` in auto mode, or while in HIGH or HALTED, is discarded.
- Switching from auto to manual while the button is held does not produce a rise. A fresh `btn_rise` is required.
- `cycle_count` increments by 1, modulo 2^COUNT_WIDTH, on each LOW → HIGH transition.

## Timing
- Reset values: `cpu_clk` = 0, `cpu_rise` = 0, `halted` = 0, `cycle_count` = 0. Internally: state LOW, `cnt` = 0, `mode_q` = 0 (manual), debouncer outputs 0.
- `rst` mid-phase forces LOW on the next edge regardless of state, including from HALTED.
- Auto mode: `cpu_clk` is high for exactly `div_eff` cycles and low for exactly `div_eff` cycles, giving period 2·`div_eff`. The duty cycle is always 50 %.
- Manual mode latency:
  - Raw button rise held stable → `cpu_clk` = 1 after DEBOUNCE_CYCLES + 3 `sys_clk` edges.
  - Release → `cpu_clk` = 0 after the same latency.
- `cpu_rise` and `cpu_clk` rise on the same edge. `halted` rises on the edge the FSM enters HALTED.
- A mode switch takes effect at the first LOW cycle after the debounced level changes. It never truncates a high phase, so no runt pulses occur.
- If `halt` and a manual `btn_rise` arrive in the same LOW cycle, HALTED wins.

## Structure
- Package `clock_pkg` holds:
  - the `clk_state_e` typedef (CLK_LOW, CLK_HIGH, CLK_HALTED);
  - `MODE_MANUAL` = 1'b0 and `MODE_AUTO` = 1'b1.
- Sub-module `debouncer` (parameter `CYCLES`; ports `sys_clk`, `rst`, `raw`, `stable`) is instantiated twice, for `mode` and `manual_toggle`.
- The top level holds the FSM, `cnt`, the `div_eff` latch and `cycle_count`.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4.
- Auto, `div` = 3, `mode` = 1 held: `cpu_clk` pattern is 3 high / 3 low repeating. `cycle_count` = 4 after 4 rises.
- Auto, `div` = 0: `cpu_clk` toggles every cycle. Change `div` to 5 mid-high-phase: the current phase stays 1 cycle, and the next phases are 5 cycles.
- Manual, button bounces 1-0-1-0-1 at 1-cycle spacing then holds high: exactly one `cpu_clk` rise, 7 edges after the final stable rise. `cycle_count` = 1.
- Flip `mode` 1 → 0 while `cpu_clk` is high in auto: the high phase completes at full length, then `cpu_clk` stays low until a button press.
- Auto, `halt` pulsed during HIGH: the phase completes, the FSM goes low, then `halted` = 1 and `cpu_clk` stays 0 for 100 cycles. `rst` then restores `halted` = 0 and `cycle_count` = 0.
- `cycle_count` with COUNT_WIDTH = 4: the 16th rise wraps the count to 0.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the CPU clock generator.
//   clk_state_e  - phase FSM states (low phase, high phase, latched halt)
//   MODE_MANUAL  - slide-switch level selecting single-step mode
//   MODE_AUTO    - slide-switch level selecting free-running mode
package clock_pkg;

    typedef enum logic [1:0] {
        CLK_LOW    = 2'd0,
        CLK_HIGH   = 2'd1,
        CLK_HALTED = 2'd2
    } clk_state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/clock_gen_if.sv
// clock_gen_if: board/control-side signals of the CPU clock generator.
//   mode          raw slide switch (1 = auto, 0 = manual), asynchronous
//   manual_toggle raw push button (1 = pressed), asynchronous and bouncy
//   halt          halt request from the control unit, sys_clk domain
//   div           auto-mode half-period in sys_clk cycles (0 acts as 1)
//   cpu_clk       registered CPU clock
//   cpu_rise      one-cycle pulse in the first cycle cpu_clk is high
//   halted        generator latched in the halted state
//   cycle_count   cpu_clk rising edges since reset, wrapping
// The generator connects through the slave modport; whoever drives the
// switches and halt uses the master modport.
interface clock_gen_if #(
    parameter int DIV_WIDTH   = 24,
    parameter int COUNT_WIDTH = 16
);
    logic                   mode;
    logic                   manual_toggle;
    logic                   halt;
    logic [DIV_WIDTH-1:0]   div;
    logic                   cpu_clk;
    logic                   cpu_rise;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] cycle_count;

    modport master (
        output mode, manual_toggle, halt, div,
        input  cpu_clk, cpu_rise, halted, cycle_count
    );

    modport slave (
        input  mode, manual_toggle, halt, div,
        output cpu_clk, cpu_rise, halted, cycle_count
    );
endinterface

// File: rtl/debouncer.sv
// debouncer: 2-FF synchroniser followed by a stability counter.
//   sys_clk  system clock
//   rst      synchronous active-high reset (stable output resets to 0)
//   raw      asynchronous, possibly bouncing input
//   stable   debounced level; flips only after CYCLES consecutive cycles in
//            which the synchronised input disagrees with it
module debouncer #(
    parameter int CYCLES = 270000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    // Counter only has to reach CYCLES-1 before the output flips.
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // This edge closes the CYCLES-th disagreeing cycle.
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/clock_gen.sv
// clock_gen: CPU clock generator derived from sys_clk.
//   sys_clk  system clock, the only clock
//   rst      synchronous active-high reset
//   bus      clock_gen_if slave modport: mode, manual_toggle, halt, div in;
//            cpu_clk, cpu_rise, halted, cycle_count out
// Auto mode produces a 50 % duty clock of half-period max(div,1); manual
// mode follows the debounced push button. Mode changes are accepted only in
// the low phase, so a high phase is never truncated. A halt request is held
// until the next point where the clock would rise, and then parks the
// generator in HALTED until reset.
module clock_gen
    import clock_pkg::*;
#(
    parameter int DIV_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int COUNT_WIDTH     = 16
) (
    input logic        sys_clk,
    input logic        rst,
    clock_gen_if.slave bus
);
    function automatic logic [DIV_WIDTH-1:0] div_sat(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    logic                   mode_db;
    logic                   btn_db;
    logic                   btn_prev;
    logic                   btn_rise;
    logic                   mode_q;
    logic                   halt_pend;
    logic                   halt_req;
    logic                   phase_done;
    logic                   cnt_clr;
    logic                   mode_load;
    logic                   rise_evt;
    logic                   cpu_rise;
    logic [DIV_WIDTH-1:0]   cnt;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic [COUNT_WIDTH-1:0] cycle_count;
    clk_state_e             state;
    clk_state_e             state_nxt;

    debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .sys_clk (sys_clk),
        .rst     (rst),
        .raw     (bus.mode),
        .stable  (mode_db)
    );

    debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .sys_clk (sys_clk),
        .rst     (rst),
        .raw     (bus.manual_toggle),
        .stable  (btn_db)
    );

    // Edge detect on the debounced level: a button already held when the
    // switch moves to manual never shows up as a rise.
    assign btn_rise   = btn_db & ~btn_prev;
    // A halt pulse seen during the high phase must still stop the next rise.
    assign halt_req   = bus.halt | halt_pend;
    assign phase_done = (cnt == div_eff - DIV_WIDTH'(1));
    assign rise_evt   = (state == CLK_LOW) && (state_nxt == CLK_HIGH);

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        mode_load = 1'b0;
        case (state)
            CLK_LOW: begin
                if (mode_db != mode_q) begin
                    // New mode starts a fresh low phase; this cycle's trigger is dropped.
                    mode_load = 1'b1;
                    cnt_clr   = 1'b1;
                end else if ((mode_q == MODE_AUTO && phase_done) ||
                             (mode_q == MODE_MANUAL && btn_rise)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = halt_req ? CLK_HALTED : CLK_HIGH;
                end
            end
            CLK_HIGH: begin
                if ((mode_q == MODE_AUTO && phase_done) ||
                    (mode_q == MODE_MANUAL && !btn_db)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = CLK_LOW;
                end
            end
            CLK_HALTED: state_nxt = CLK_HALTED;
            default:    state_nxt = CLK_LOW;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= CLK_LOW;
            cnt         <= '0;
            div_eff     <= div_sat(bus.div);
            mode_q      <= MODE_MANUAL;
            halt_pend   <= 1'b0;
            btn_prev    <= 1'b0;
            cpu_rise    <= 1'b0;
            cycle_count <= '0;
        end else begin
            state     <= state_nxt;
            btn_prev  <= btn_db;
            halt_pend <= halt_req;
            cpu_rise  <= rise_evt;
            if (mode_load) begin
                mode_q <= mode_db;
            end
            // Every phase entry samples div, so a new value applies from the next boundary.
            if (cnt_clr) begin
                cnt     <= '0;
                div_eff <= div_sat(bus.div);
            end else if (mode_q == MODE_AUTO && state != CLK_HALTED) begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
            if (rise_evt) begin
                cycle_count <= cycle_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.cpu_clk     = (state == CLK_HIGH);
    assign bus.halted      = (state == CLK_HALTED);
    assign bus.cpu_rise    = cpu_rise;
    assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_clock_gen.sv
// tb_clock_gen: directed bench for clock_gen with DEBOUNCE_CYCLES = 4,
// DIV_WIDTH = 8 and COUNT_WIDTH = 4.
module tb_clock_gen;
    logic clk;
    logic rst;

    clock_gen_if #(.DIV_WIDTH(8), .COUNT_WIDTH(4)) bus ();

    clock_gen #(
        .DIV_WIDTH       (8),
        .DEBOUNCE_CYCLES (4),
        .COUNT_WIDTH     (4)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mode;
        logic       btn;
        logic       halt;
        logic [7:0] div;
        int         n;
        logic       clk_e;
        logic       rise_e;
        logic       halted_e;
        logic [3:0] cnt_e;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic r, logic m, logic b, logic h, logic [7:0] d, int n,
                                logic c, logic ri, logic ha, logic [3:0] ce);
        vec_t v;
        v.rst = r; v.mode = m; v.btn = b; v.halt = h; v.div = d; v.n = n;
        v.clk_e = c; v.rise_e = ri; v.halted_e = ha; v.cnt_e = ce;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (bus.cpu_rise) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int bad;

        rst = 1'b1;
        bus.mode = 1'b0;
        bus.manual_toggle = 1'b0;
        bus.halt = 1'b0;
        bus.div = 8'd3;

        //        rst mode btn halt div  n   clk rise hlt cnt
        tbl.push_back(mk(1, 0, 0, 0, 8'd3, 2,  0, 0, 0, 4'd0));
        // auto, div = 3: mode settles after 6 edges, loads on the 7th
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 9,  0, 0, 0, 4'd0));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 1,  1, 1, 0, 4'd1));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 2,  1, 0, 0, 4'd1));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 3,  0, 0, 0, 4'd1));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 1,  1, 1, 0, 4'd2));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 2,  1, 0, 0, 4'd2));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 3,  0, 0, 0, 4'd2));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 1,  1, 1, 0, 4'd3));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 2,  1, 0, 0, 4'd3));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 3,  0, 0, 0, 4'd3));
        tbl.push_back(mk(0, 1, 0, 0, 8'd3, 1,  1, 1, 0, 4'd4));
        // div = 0 mid-high: current phase keeps 3, then 1-cycle phases
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 2,  1, 0, 0, 4'd4));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 1,  0, 0, 0, 4'd4));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 1,  1, 1, 0, 4'd5));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 1,  0, 0, 0, 4'd5));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0, 1,  1, 1, 0, 4'd6));
        // div = 5 during a 1-cycle high phase: that phase stays 1 cycle
        tbl.push_back(mk(0, 1, 0, 0, 8'd5, 5,  0, 0, 0, 4'd6));
        tbl.push_back(mk(0, 1, 0, 0, 8'd5, 1,  1, 1, 0, 4'd7));
        tbl.push_back(mk(0, 1, 0, 0, 8'd5, 4,  1, 0, 0, 4'd7));
        tbl.push_back(mk(0, 1, 0, 0, 8'd5, 5,  0, 0, 0, 4'd7));
        // 8-cycle high phase; switch to manual during it: no truncation
        tbl.push_back(mk(0, 1, 0, 0, 8'd8, 1,  1, 1, 0, 4'd8));
        tbl.push_back(mk(0, 0, 0, 0, 8'd8, 7,  1, 0, 0, 4'd8));
        tbl.push_back(mk(0, 0, 0, 0, 8'd8, 13, 0, 0, 0, 4'd8));
        // manual: button bounces 1-0-1-0 then holds; one rise 7 edges later
        tbl.push_back(mk(0, 0, 1, 0, 8'd8, 1,  0, 0, 0, 4'd8));
        tbl.push_back(mk(0, 0, 0, 0, 8'd8, 1,  0, 0, 0, 4'd8));
        tbl.push_back(mk(0, 0, 1, 0, 8'd8, 1,  0, 0, 0, 4'd8));
        tbl.push_back(mk(0, 0, 0, 0, 8'd8, 1,  0, 0, 0, 4'd8));
        tbl.push_back(mk(0, 0, 1, 0, 8'd8, 6,  0, 0, 0, 4'd8));
        tbl.push_back(mk(0, 0, 1, 0, 8'd8, 1,  1, 1, 0, 4'd9));
        tbl.push_back(mk(0, 0, 1, 0, 8'd8, 9,  1, 0, 0, 4'd9));
        // release: low again after the same 7-edge latency
        tbl.push_back(mk(0, 0, 0, 0, 8'd8, 6,  1, 0, 0, 4'd9));
        tbl.push_back(mk(0, 0, 0, 0, 8'd8, 4,  0, 0, 0, 4'd9));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst               = tbl[i].rst;
                bus.mode          = tbl[i].mode;
                bus.manual_toggle = tbl[i].btn;
                bus.halt          = tbl[i].halt;
                bus.div           = tbl[i].div;
                tick();
                check($sformatf("row%0d.%0d cpu_clk", i, k), int'(bus.cpu_clk), int'(tbl[i].clk_e));
                check($sformatf("row%0d.%0d cpu_rise", i, k), int'(bus.cpu_rise), int'(tbl[i].rise_e));
                check($sformatf("row%0d.%0d halted", i, k), int'(bus.halted), int'(tbl[i].halted_e));
                check($sformatf("row%0d.%0d cycle_count", i, k), int'(bus.cycle_count), int'(tbl[i].cnt_e));
            end
        end

        // Halt pulsed during a high phase (auto, div = 2).
        bus.mode = 1'b0; bus.manual_toggle = 1'b0; bus.halt = 1'b0; bus.div = 8'd2;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.mode = 1'b1;
        repeat (8) tick();
        check("halt_seq low before rise", int'(bus.cpu_clk), 0);
        tick();
        check("halt_seq rise", int'(bus.cpu_rise), 1);
        check("halt_seq count1", int'(bus.cycle_count), 1);
        bus.halt = 1'b1;
        tick();
        check("halt_seq high completes", int'(bus.cpu_clk), 1);
        check("halt_seq not halted in high", int'(bus.halted), 0);
        bus.halt = 1'b0;
        tick();
        check("halt_seq low phase clk", int'(bus.cpu_clk), 0);
        check("halt_seq low phase halted", int'(bus.halted), 0);
        tick();
        check("halt_seq low phase 2 halted", int'(bus.halted), 0);
        tick();
        check("halt_seq halted", int'(bus.halted), 1);
        check("halt_seq halted clk", int'(bus.cpu_clk), 0);
        check("halt_seq halted count", int'(bus.cycle_count), 1);
        bad = 0;
        repeat (100) begin
            tick();
            if (bus.cpu_clk !== 1'b0 || bus.halted !== 1'b1) bad++;
        end
        check("halt_seq 100 cycles parked", bad, 0);
        rst = 1'b1;
        tick();
        check("halt_seq rst halted", int'(bus.halted), 0);
        check("halt_seq rst count", int'(bus.cycle_count), 0);
        check("halt_seq rst clk", int'(bus.cpu_clk), 0);

        // Halt and manual button rise in the same low cycle: halt wins.
        bus.mode = 1'b0;
        tick();
        rst = 1'b0;
        bus.manual_toggle = 1'b1;
        repeat (5) tick();
        tick();
        check("halt_btn before clk", int'(bus.cpu_clk), 0);
        check("halt_btn before halted", int'(bus.halted), 0);
        bus.halt = 1'b1;
        tick();
        check("halt_btn halted", int'(bus.halted), 1);
        check("halt_btn clk", int'(bus.cpu_clk), 0);
        check("halt_btn rise", int'(bus.cpu_rise), 0);
        check("halt_btn count", int'(bus.cycle_count), 0);
        bus.halt = 1'b0;
        repeat (3) tick();
        check("halt_btn stays halted", int'(bus.halted), 1);

        // 4-bit cycle_count wraps on the 16th rise; then rst mid-high.
        bus.manual_toggle = 1'b0; bus.mode = 1'b1; bus.div = 8'd3;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            wait_rise(20, ok);
            check($sformatf("wrap rise%0d seen", k), int'(ok), 1);
            if (!ok) break;
            check($sformatf("wrap count after rise%0d", k), int'(bus.cycle_count), k % 16);
        end
        check("wrap high before rst", int'(bus.cpu_clk), 1);
        rst = 1'b1;
        tick();
        check("rst mid-high clk", int'(bus.cpu_clk), 0);
        check("rst mid-high count", int'(bus.cycle_count), 0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
